// File: rtl/toy_sa_lane_port.sv
// Row-edge endpoint of one systolic-array lane: activation skew pipe, weight
// shift chain, and accumulator snapshot buffer drained one word per shift.
module toy_sa_lane_port #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int SKEW       = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_WIDTH-1:0]       sa_dout,
    input  logic                        sa_dout_en,
    input  logic [DATA_WIDTH-1:0]       sa_dout_y,
    input  logic                        sa_load_en,
    input  logic                        sa_shift_en,
    output logic [DATA_WIDTH-1:0]       sa_din,
    output logic [DATA_WIDTH-1:0]       pe_x,
    output logic                        pe_x_vld,
    output logic [DEPTH*DATA_WIDTH-1:0] pe_w,
    input  logic [DEPTH*DATA_WIDTH-1:0] pe_acc,
    input  logic                        pe_acc_done,
    output logic                        pe_acc_clr,
    output logic                        busy,
    output logic                        overrun,
    output logic                        underrun
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, DRAIN} state_t;
    state_t state_q;

    logic [DATA_WIDTH-1:0] xpipe_q [SKEW+1];
    logic [SKEW:0]         vpipe_q;
    logic [DATA_WIDTH-1:0] w_q     [DEPTH];

    logic [DATA_WIDTH-1:0] res_q   [DEPTH];
    logic [DATA_WIDTH-1:0] res_d   [DEPTH];
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] sa_din_q, sa_din_d;
    logic                  overrun_q, overrun_d;
    logic                  underrun_q, underrun_d;
    logic                  acc_clr_q;
    logic                  busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k <= SKEW; k++) xpipe_q[k] <= '0;
            vpipe_q <= '0;
        end else begin
            xpipe_q[0] <= sa_dout;
            vpipe_q[0] <= sa_dout_en;
            for (int unsigned k = 1; k <= SKEW; k++) begin
                xpipe_q[k] <= xpipe_q[k-1];
                vpipe_q[k] <= vpipe_q[k-1];
            end
        end
    end

    assign pe_x     = xpipe_q[SKEW];
    assign pe_x_vld = vpipe_q[SKEW];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) w_q[k] <= '0;
        end else if (sa_load_en) begin
            w_q[0] <= sa_dout_y;
            for (int unsigned k = 1; k < DEPTH; k++) w_q[k] <= w_q[k-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_pe_w
        assign pe_w[g*DATA_WIDTH +: DATA_WIDTH] = w_q[g];
    end

    // Pop is evaluated on the old buffer first; a capture then overwrites it,
    // so a simultaneous capture+pop only loses words beyond the one popped.
    always_comb begin
        res_d      = res_q;
        cnt_d      = cnt_q;
        sa_din_d   = sa_din_q;
        overrun_d  = overrun_q;
        underrun_d = underrun_q;
        if (sa_shift_en) begin
            if (cnt_q != '0) begin
                sa_din_d = res_q[0];
                for (int unsigned k = 0; k < DEPTH - 1; k++) res_d[k] = res_q[k+1];
                res_d[DEPTH-1] = '0;
                cnt_d          = cnt_q - CW'(1);
            end else begin
                sa_din_d   = '0;
                underrun_d = 1'b1;
            end
        end
        if (pe_acc_done) begin
            if (cnt_q > CW'(sa_shift_en)) overrun_d = 1'b1;
            for (int unsigned k = 0; k < DEPTH; k++)
                res_d[k] = pe_acc[k*DATA_WIDTH +: DATA_WIDTH];
            cnt_d = CW'(DEPTH);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) res_q[k] <= '0;
            cnt_q      <= '0;
            sa_din_q   <= '0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
            acc_clr_q  <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
        end else begin
            res_q      <= res_d;
            cnt_q      <= cnt_d;
            sa_din_q   <= sa_din_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
            acc_clr_q  <= pe_acc_done;
            busy_q     <= (cnt_d != '0);
            case (state_q)
                IDLE:    if (pe_acc_done) state_q <= DRAIN;
                DRAIN:   if (cnt_d == '0) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sa_din     = sa_din_q;
    assign pe_acc_clr = acc_clr_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;
    assign underrun   = underrun_q;
endmodule

// File: tb/tb_toy_sa_lane_port.sv
// Scoreboard bench for toy_sa_lane_port (DEPTH=4, SKEW=2): queued expectations
// for pe_x beats and sa_din pops, consumed by independent monitors.
module tb_toy_sa_lane_port;
    localparam int DW = 32;
    localparam int D  = 4;
    localparam int SK = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] sa_dout, sa_dout_y, sa_din, pe_x;
    logic          sa_dout_en, sa_load_en, sa_shift_en, pe_x_vld;
    logic [D*DW-1:0] pe_w, pe_acc;
    logic          pe_acc_done, pe_acc_clr, busy, overrun, underrun;

    toy_sa_lane_port #(.DATA_WIDTH(DW), .DEPTH(D), .SKEW(SK)) dut (
        .clk(clk), .rst_n(rst_n),
        .sa_dout(sa_dout), .sa_dout_en(sa_dout_en),
        .sa_dout_y(sa_dout_y), .sa_load_en(sa_load_en),
        .sa_shift_en(sa_shift_en), .sa_din(sa_din),
        .pe_x(pe_x), .pe_x_vld(pe_x_vld), .pe_w(pe_w),
        .pe_acc(pe_acc), .pe_acc_done(pe_acc_done), .pe_acc_clr(pe_acc_clr),
        .busy(busy), .overrun(overrun), .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [DW-1:0] d; } xexp_t;
    xexp_t         xq[$];
    logic [DW-1:0] dq[$];
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_err = 0;
    logic          shift_seen = 1'b0;

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        shift_seen <= rst_n && sa_shift_en;
    end

    task automatic check(input string name, input logic [D*DW-1:0] act, input logic [D*DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (pe_x_vld === 1'b1) begin
            if (xq.size() == 0) begin
                check("pe_x_unexpected_vld", 1, 0);
            end else begin
                xexp_t e;
                e = xq.pop_front();
                check("pe_x_data", pe_x, e.d);
                check("pe_x_cycle", cyc, e.cyc);
            end
        end
        if (shift_seen) begin
            if (dq.size() == 0) check("sa_din_unexpected_pop", 1, 0);
            else check("sa_din", sa_din, dq.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop(input logic [DW-1:0] exp);
        dq.push_back(exp);
        sa_shift_en = 1'b1;
        tick();
        sa_shift_en = 1'b0;
    endtask

    task automatic capture(input logic [D*DW-1:0] acc);
        pe_acc      = acc;
        pe_acc_done = 1'b1;
        tick();
        pe_acc_done = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; sa_dout = '0; sa_dout_en = 1'b0; sa_dout_y = '0;
        sa_load_en = 1'b0; sa_shift_en = 1'b0; pe_acc = '0; pe_acc_done = 1'b0;
        tick(); tick();
        check("rst_sa_din", sa_din, 0);
        check("rst_pe_x_vld", pe_x_vld, 0);
        check("rst_pe_w", pe_w, 0);
        check("rst_flags", {pe_acc_clr, busy, overrun, underrun}, 0);
        rst_n = 1'b1;
        tick();

        // single activation beat, then a 4-beat burst
        sa_dout = 32'h11; sa_dout_en = 1'b1;
        xq.push_back('{cyc + SK + 1, 32'h11});
        tick();
        sa_dout = 32'h99; sa_dout_en = 1'b0;
        repeat (4) tick();
        for (int i = 1; i <= 4; i++) begin
            sa_dout = DW'(i); sa_dout_en = 1'b1;
            xq.push_back('{cyc + SK + 1, DW'(i)});
            tick();
        end
        sa_dout_en = 1'b0;
        repeat (5) tick();

        // weight chain
        for (int i = 0; i < 4; i++) begin
            sa_dout_y = DW'(32'hA + i); sa_load_en = 1'b1;
            tick();
        end
        sa_load_en = 1'b0; sa_dout_y = 32'hFF;
        check("pe_w_loaded", pe_w, {32'hA, 32'hB, 32'hC, 32'hD});
        repeat (10) tick();
        check("pe_w_hold", pe_w, {32'hA, 32'hB, 32'hC, 32'hD});

        // capture and full drain
        capture({32'h40, 32'h30, 32'h20, 32'h10});
        check("clr_pulse", pe_acc_clr, 1);
        check("busy_after_capture", busy, 1);
        tick();
        check("clr_one_cycle", pe_acc_clr, 0);
        for (int i = 1; i <= 4; i++) begin
            dq.push_back(DW'(32'h10 * i));
            sa_shift_en = 1'b1;
            tick();
        end
        sa_shift_en = 1'b0;
        check("busy_after_drain", busy, 0);
        check("flags_after_drain", {overrun, underrun}, 0);

        // underrun
        pop(32'h0);
        check("underrun_set", underrun, 1);
        repeat (3) tick();
        check("underrun_sticky", underrun, 1);
        check("sa_din_hold", sa_din, 0);

        // overrun with simultaneous capture and pop
        capture({32'h40, 32'h30, 32'h20, 32'h10});
        pop(32'h10);
        pe_acc = {32'h8, 32'h7, 32'h6, 32'h5};
        pe_acc_done = 1'b1; sa_shift_en = 1'b1;
        dq.push_back(32'h20);
        tick();
        pe_acc_done = 1'b0; sa_shift_en = 1'b0;
        check("overrun_set", overrun, 1);
        check("busy_after_recapture", busy, 1);
        check("clr_after_recapture", pe_acc_clr, 1);
        for (int i = 5; i <= 8; i++) pop(DW'(i));
        check("busy_after_second_drain", busy, 0);

        // reset mid-drain
        capture({32'hD4, 32'hC3, 32'hB2, 32'hA1});
        pop(32'hA1);
        pop(32'hB2);
        check("busy_mid_drain", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_sa_din", sa_din, 0);
        check("rst_mid_flags", {overrun, underrun, pe_acc_clr}, 0);
        check("rst_mid_pe_w", pe_w, 0);
        pop(32'h0);
        check("underrun_after_reset", underrun, 1);
        tick(); tick();

        check("pe_x_queue_empty", xq.size(), 0);
        check("sa_din_queue_empty", dq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
